instruction_fetch_unit: RTL and testbench

//  Program-counter and IF/ID stage directly upstream of Instruction_Memory. Drives Inst_Address to the

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_if.sv | 56 +++++
 rtl/if_id_pipe_reg.sv | 57 +++++
 rtl/instruction_fetch_unit.sv | 111 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared constants and types for the instruction fetch slice.
//   INSTR_W / XLEN : instruction and address widths
//   NOP_INSTR      : canonical NOP (addi x0,x0,0) loaded into IF/ID on reset
//   fetch_state_e  : fetch FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned XLEN    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_END   = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the instruction-memory bus, redirect input and IF/ID handshake.
//   Inst_Address   : byte address to instruction memory (fetch -> mem)
//   Instruction    : word returned combinationally for Inst_Address
//   redirect_valid : branch/jump taken this cycle
//   redirect_pc    : redirect target byte address
//   id_ready       : decode accepts id_instr this cycle
//   id_valid       : IF/ID register holds a valid instruction
//   id_instr       : fetched instruction word
//   id_pc          : address of id_instr
//   id_pc_plus4    : id_pc + 4 (mod 2^32)
//   fetch_fault    : sticky misaligned-redirect flag
// Modports: master = fetch unit, slave = surrounding core / memory.
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  import riscv_pkg::*;

  logic [XLEN-1:0]    Inst_Address;
  logic [INSTR_W-1:0] Instruction;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               id_ready;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [XLEN-1:0]    id_pc;
  logic [XLEN-1:0]    id_pc_plus4;
  logic               fetch_fault;

  modport master (
    output Inst_Address,
    input  Instruction,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output fetch_fault
  );

  modport slave (
    input  Inst_Address,
    output Instruction,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  fetch_fault
  );

endinterface

// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
// IF/ID pipeline register with load / hold / flush / clear controls.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : capture instr_i / pc_i and mark valid
//   flush_i     : drop the held instruction (redirect); wins over load_i
//   clear_i     : held instruction consumed with nothing new to load
//   instr_i     : instruction word from memory
//   pc_i        : address of instr_i
//   valid_o, instr_o, pc_o, pc_plus4_o : registered IF/ID contents
// With no control asserted the register holds (decode stall).
// ---------------------------------------------------------------------------
module if_id_pipe_reg
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [XLEN-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    pc_plus4_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    pc_plus4_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_i + 32'd4;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// PC register + fetch FSM feeding an IF/ID register, directly upstream of a
// combinational instruction memory.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   bus   : instruction_fetch_unit_if.master (memory bus, redirect, IF/ID)
// Parameters: RESET_PC (PC after reset), IMEM_BYTES (memory size in bytes).
// Optional feature macro IFETCH_MISALIGN_TRAP_EN: a misaligned redirect enters
// FAULT and raises a sticky fetch_fault. Without it the low two target bits
// are forced to zero and fetch_fault is tied low.
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - 4);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tgt_pc;
  logic            tgt_misaligned;
  logic            slot_free;
  logic            fire;
  logic            pipe_clear;

  always_comb begin
    tgt_pc         = bus.redirect_pc & ~32'h3;
    tgt_misaligned = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    tgt_misaligned = |bus.redirect_pc[1:0];
`endif
    slot_free  = !bus.id_valid || bus.id_ready;
    // The range guard keeps a fetch from ever issuing past the end of memory.
    fire       = !bus.redirect_valid && (state_q == S_FETCH) && slot_free
                 && (pc_q <= LAST_PC);
    pipe_clear = slot_free && !fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
    end else if (bus.redirect_valid) begin
      if (tgt_misaligned) begin
        state_q <= S_FAULT;
      end else begin
        pc_q    <= tgt_pc;
        state_q <= (tgt_pc <= LAST_PC) ? S_FETCH : S_END;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (fire) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= (pc_q == LAST_PC) ? S_END : S_FETCH;
          end else if (!slot_free) begin
            state_q <= S_HOLD;
          end else begin
            state_q <= S_END;
          end
        end
        S_HOLD: begin
          if (bus.id_ready) state_q <= (pc_q <= LAST_PC) ? S_FETCH : S_END;
        end
        default: state_q <= state_q;
      endcase
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fault_q;

  // Sticky until reset or an aligned redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      fault_q <= tgt_misaligned;
    end
  end

  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  assign bus.Inst_Address = pc_q;

  if_id_pipe_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load_i     (fire),
    .flush_i    (bus.redirect_valid),
    .clear_i    (pipe_clear),
    .instr_i    (bus.Instruction),
    .pc_i       (pc_q),
    .valid_o    (bus.id_valid),
    .instr_o    (bus.id_instr),
    .pc_o       (bus.id_pc),
    .pc_plus4_o (bus.id_pc_plus4)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench: 8-word combinational instruction memory, hand-computed
// expected IF/ID contents for sequential fetch, stall, redirect, end of
// memory, misaligned redirect and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [31:0] mem [0:7];
  logic [31:0] mem_word;
  assign mem_word = mem[bus.Inst_Address[4:2]];
  assign bus.Instruction = (bus.Inst_Address[31:5] == '0 && bus.Inst_Address[1:0] == 2'b00)
                           ? mem_word : 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  logic [31:0] seq_instr [0:4];

  initial begin
    mem[0] = 32'hFFC4A303; mem[1] = 32'h0064A423; mem[2] = 32'h0062E233;
    mem[3] = 32'h00108113; mem[4] = 32'h00200113; mem[5] = 32'h00500293;
    mem[6] = 32'h00628333; mem[7] = 32'h01404083;
    seq_instr[0] = 32'hFFC4A303; seq_instr[1] = 32'h0064A423;
    seq_instr[2] = 32'h0062E233; seq_instr[3] = 32'h00108113;
    seq_instr[4] = 32'h00200113;

    // Reset state
    do_reset();
    chk("rst_valid", {31'h0, bus.id_valid}, 32'h0);
    chk("rst_instr", bus.id_instr, 32'h0000_0013);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_pc4", bus.id_pc_plus4, 32'h0);
    chk("rst_addr", bus.Inst_Address, 32'h0);
    chk("rst_fault", {31'h0, bus.fetch_fault}, 32'h0);

    // 1. Back-to-back fetch
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_valid", {31'h0, bus.id_valid}, 32'h1);
      chk("t1_instr", bus.id_instr, seq_instr[i]);
      chk("t1_pc", bus.id_pc, 32'(i * 4));
      chk("t1_pc4", bus.id_pc_plus4, 32'(i * 4 + 4));
    end
    chk("t1_addr", bus.Inst_Address, 32'd20);

    // 2. Stall at id_pc=8
    do_reset();
    step(); step(); step();
    chk("t2_pre_pc", bus.id_pc, 32'd8);
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_instr", bus.id_instr, 32'h0062E233);
      chk("t2_hold_valid", {31'h0, bus.id_valid}, 32'h1);
      chk("t2_hold_addr", bus.Inst_Address, 32'd12);
    end
    bus.id_ready = 1'b1;
    step();
    chk("t2_rel_valid", {31'h0, bus.id_valid}, 32'h0);
    step();
    chk("t2_next_instr", bus.id_instr, 32'h00108113);
    chk("t2_next_pc", bus.id_pc, 32'd12);

    // 3. Redirect while HOLD at id_pc=4
    do_reset();
    step(); step();
    chk("t3_pre_pc", bus.id_pc, 32'd4);
    bus.id_ready = 1'b0;
    step();
    chk("t3_held_pc", bus.id_pc, 32'd4);
    bus.id_ready = 1'b1;
    redirect(32'h10);
    chk("t3_flush_valid", {31'h0, bus.id_valid}, 32'h0);
    chk("t3_flush_addr", bus.Inst_Address, 32'h10);
    step();
    chk("t3_valid", {31'h0, bus.id_valid}, 32'h1);
    chk("t3_pc", bus.id_pc, 32'h10);
    chk("t3_instr", bus.id_instr, 32'h00200113);

    // 4. Run to end of memory, then restart
    step(); step(); step();
    chk("t4_last_pc", bus.id_pc, 32'd28);
    chk("t4_last_instr", bus.id_instr, 32'h01404083);
    chk("t4_last_addr", bus.Inst_Address, 32'd32);
    step();
    chk("t4_end_valid", {31'h0, bus.id_valid}, 32'h0);
    chk("t4_end_addr", bus.Inst_Address, 32'd32);
    step();
    chk("t4_end_valid2", {31'h0, bus.id_valid}, 32'h0);
    chk("t4_end_addr2", bus.Inst_Address, 32'd32);
    redirect(32'h0);
    chk("t4_rd_valid", {31'h0, bus.id_valid}, 32'h0);
    step();
    chk("t4_restart_instr", bus.id_instr, 32'hFFC4A303);
    chk("t4_restart_pc", bus.id_pc, 32'h0);

    // 5. Misaligned redirect
    redirect(32'h6);
    chk("t5_valid", {31'h0, bus.id_valid}, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("t5_fault", {31'h0, bus.fetch_fault}, 32'h1);
    step();
    chk("t5_fault_sticky", {31'h0, bus.fetch_fault}, 32'h1);
    chk("t5_fault_valid", {31'h0, bus.id_valid}, 32'h0);
    redirect(32'h0);
    chk("t5_fault_clr", {31'h0, bus.fetch_fault}, 32'h0);
    step();
    chk("t5_resume_instr", bus.id_instr, 32'hFFC4A303);
    chk("t5_resume_valid", {31'h0, bus.id_valid}, 32'h1);
`else
    chk("t5_fault", {31'h0, bus.fetch_fault}, 32'h0);
    chk("t5_addr", bus.Inst_Address, 32'h4);
    step();
    chk("t5_instr", bus.id_instr, 32'h0064A423);
    chk("t5_pc", bus.id_pc, 32'h4);
    chk("t5_pc4", bus.id_pc_plus4, 32'h8);
`endif

    // 6. Reset mid-stream at id_pc=12 (concurrent redirect ignored)
    do_reset();
    step(); step(); step(); step();
    chk("t6_pre_pc", bus.id_pc, 32'd12);
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h18;
    step();
    chk("t6_valid", {31'h0, bus.id_valid}, 32'h0);
    chk("t6_instr", bus.id_instr, 32'h0000_0013);
    chk("t6_addr", bus.Inst_Address, 32'h0);
    chk("t6_pc", bus.id_pc, 32'h0);
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    chk("t6_after_instr", bus.id_instr, 32'hFFC4A303);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
